// File: rtl/sample_sequencer.sv
// Per-sample scheduler for the ADC -> filter -> DAC datapath.
// Issues converter/filter pulses once per period; flags overrun and timeout.
module sample_sequencer #(
    parameter int DIVIDER  = 50,
    parameter int TIMEOUT  = 200,
    parameter int FILT_LAT = 1,
    parameter int DATA_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    output logic              adc_start_o,
    input  logic              adc_idle_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              filt_strobe_o,
    output logic [DATA_W-1:0] filt_data_o,
    input  logic [DATA_W-1:0] filt_result_i,
    output logic              dac_start_o,
    input  logic              dac_idle_i,
    output logic [DATA_W-1:0] dac_data_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_o,
    input  logic              flags_clr_i,
    output logic [15:0]       sample_cnt_o
);

    localparam int PW = $clog2(DIVIDER);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int LW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADC_START,
        S_ADC_WAIT,
        S_FILT,
        S_DAC_START,
        S_DAC_WAIT
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_period;
    logic [WW-1:0]       r_wait;
    logic [LW-1:0]       r_lat;
    logic                r_adc_start;
    logic                r_filt_strobe;
    logic                r_dac_start;
    logic [DATA_W-1:0]   r_filt_data;
    logic [DATA_W-1:0]   r_dac_data;
    logic [15:0]         r_sample_cnt;
    logic                r_overrun;
    logic                r_timeout;

    logic                w_tick;
    logic                w_ovr_set;
    logic                w_first;
    logic                w_wait_to;
    logic [DATA_W-1:0]   w_sel;

    assign w_tick    = enable_i && (r_period == PW'(DIVIDER - 1));
    assign w_ovr_set = w_tick && (r_state != S_IDLE);
    // Converters need one cycle to drop idle after a start pulse.
    assign w_first   = (r_wait == '0);
    assign w_wait_to = (r_wait == WW'(TIMEOUT - 1));

    always_comb begin
        w_sel = '0;
        case (mode_i)
            2'd1:    w_sel = r_filt_data;
            2'd2:    w_sel = filt_result_i;
            default: w_sel = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_period <= '0;
        end else if (!enable_i || w_tick) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_lat         <= '0;
            r_adc_start   <= 1'b0;
            r_filt_strobe <= 1'b0;
            r_dac_start   <= 1'b0;
            r_filt_data   <= '0;
            r_dac_data    <= '0;
            r_sample_cnt  <= '0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_adc_start   <= 1'b0;
            r_filt_strobe <= 1'b0;
            r_dac_start   <= 1'b0;
            if (flags_clr_i) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state     <= S_ADC_START;
                        r_adc_start <= 1'b1;
                    end
                end
                S_ADC_START: begin
                    r_state <= S_ADC_WAIT;
                    r_wait  <= '0;
                end
                S_ADC_WAIT: begin
                    if (!w_first && adc_idle_i) begin
                        r_filt_data   <= adc_data_i;
                        r_filt_strobe <= 1'b1;
                        r_lat         <= '0;
                        r_state       <= S_FILT;
                    end else if (w_wait_to) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FILT: begin
                    if (r_lat == LW'(FILT_LAT)) begin
                        r_dac_data  <= w_sel;
                        r_dac_start <= 1'b1;
                        r_state     <= S_DAC_START;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_DAC_START: begin
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                    r_wait       <= '0;
                    r_state      <= S_DAC_WAIT;
                end
                S_DAC_WAIT: begin
                    if (!w_first && dac_idle_i) begin
                        r_state <= S_IDLE;
                    end else if (w_wait_to) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign adc_start_o   = r_adc_start;
    assign filt_strobe_o = r_filt_strobe;
    assign filt_data_o   = r_filt_data;
    assign dac_start_o   = r_dac_start;
    assign dac_data_o    = r_dac_data;
    assign busy_o        = (r_state != S_IDLE);
    assign overrun_o     = r_overrun;
    assign timeout_o     = r_timeout;
    assign sample_cnt_o  = r_sample_cnt;

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: converter/filter models, a timeline
// model of each sample, per-cycle compare and directed scenarios.
module tb_sample_sequencer;

    localparam int DIV = 50;
    localparam int TMO = 200;
    localparam int FL  = 1;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          enable_i;
    logic [1:0]    mode_i;
    logic          adc_start_o;
    logic          adc_idle_i;
    logic [DW-1:0] adc_data_i;
    logic          filt_strobe_o;
    logic [DW-1:0] filt_data_o;
    logic [DW-1:0] filt_result_i;
    logic          dac_start_o;
    logic          dac_idle_i;
    logic [DW-1:0] dac_data_o;
    logic          busy_o;
    logic          overrun_o;
    logic          timeout_o;
    logic          flags_clr_i;
    logic [15:0]   sample_cnt_o;

    always #10 clk = ~clk;

    sample_sequencer #(
        .DIVIDER(DIV), .TIMEOUT(TMO), .FILT_LAT(FL), .DATA_W(DW)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .enable_i(enable_i),
        .mode_i(mode_i), .adc_start_o(adc_start_o),
        .adc_idle_i(adc_idle_i), .adc_data_i(adc_data_i),
        .filt_strobe_o(filt_strobe_o), .filt_data_o(filt_data_o),
        .filt_result_i(filt_result_i), .dac_start_o(dac_start_o),
        .dac_idle_i(dac_idle_i), .dac_data_o(dac_data_o),
        .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
        .flags_clr_i(flags_clr_i), .sample_cnt_o(sample_cnt_o)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_stb  = 0;
    int n_adcm = 0;

    int adc_lat = 20;
    int dac_lat = 5;
    bit adc_stuck = 1'b0;
    int adc_cnt = 0;
    int dac_cnt = 0;
    int preload_seq = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (filt_strobe_o) n_stb <= n_stb + 1;
    always @(posedge clk) if (adc_start_o) n_adcm <= n_adcm + 1;

    // Converters go busy the cycle after a start and stay busy for *_lat cycles.
    always @(posedge clk) begin
        if (adc_start_o) adc_cnt <= adc_lat;
        else if (adc_cnt > 0) adc_cnt <= adc_cnt - 1;
        if (dac_start_o) dac_cnt <= dac_lat;
        else if (dac_cnt > 0) dac_cnt <= dac_cnt - 1;
    end
    assign adc_idle_i = (adc_cnt == 0) && !adc_stuck;
    assign dac_idle_i = (dac_cnt == 0);

    // Filter: negation, result valid one cycle after the strobe.
    always @(posedge clk) begin
        if (!reset_ni) filt_result_i <= '0;
        else if (filt_strobe_o) filt_result_i <= -filt_data_o;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic logic [15:0] msel(input logic [1:0] m,
                                         input logic [15:0] x);
        if (m == 2'd1) return x;
        if (m == 2'd2) return -x;
        return 16'h0000;
    endfunction

    // Timeline model: each sample is a set of absolute cycle numbers.
    int          m_per = 0;
    bit          m_act = 1'b0;
    bit          m_to  = 1'b0;
    int          m_s, m_c, m_d, m_end;
    bit          m_ovr = 1'b0;
    bit          m_tmo = 1'b0;
    logic [15:0] m_filt = '0;
    logic [15:0] m_dac  = '0;
    logic [15:0] m_cnt  = '0;
    int          pre_seen = 0;

    always @(negedge clk) begin : cmp
        bit e_busy, tick, ovr_ev, to_ev;
        if (pre_seen != preload_seq) begin
            pre_seen = preload_seq;
            m_cnt = 16'hFFFF;
        end
        if (!reset_ni) begin
            chk("rst_busy", busy_o, 0);
            chk("rst_adc_start", adc_start_o, 0);
            chk("rst_strobe", filt_strobe_o, 0);
            chk("rst_dac_start", dac_start_o, 0);
            chk("rst_filt_data", filt_data_o, 0);
            chk("rst_dac_data", dac_data_o, 0);
            chk("rst_cnt", sample_cnt_o, 0);
            chk("rst_overrun", overrun_o, 0);
            chk("rst_timeout", timeout_o, 0);
            m_act = 0; m_per = 0; m_ovr = 0; m_tmo = 0;
            m_filt = '0; m_dac = '0; m_cnt = '0;
        end else begin
            e_busy = m_act && cyc >= m_s && cyc <= m_end;
            chk("busy", busy_o, e_busy);
            chk("adc_start", adc_start_o, m_act && cyc == m_s);
            chk("strobe", filt_strobe_o, m_act && !m_to && cyc == m_c + 1);
            chk("dac_start", dac_start_o, m_act && !m_to && cyc == m_d);
            chk("filt_data", filt_data_o, m_filt);
            chk("dac_data", dac_data_o, m_dac);
            chk("cnt", sample_cnt_o, m_cnt);
            chk("overrun", overrun_o, m_ovr);
            chk("timeout", timeout_o, m_tmo);
            tick = enable_i && (m_per == DIV - 1);
            if (m_act && !m_to) begin
                if (cyc == m_c) m_filt = adc_data_i;
                if (cyc + 1 == m_d) m_dac = msel(mode_i, m_filt);
                if (cyc == m_d) m_cnt = m_cnt + 16'd1;
            end
            ovr_ev = tick && e_busy;
            to_ev  = m_act && m_to && cyc == m_s + TMO;
            if (ovr_ev) m_ovr = 1;
            else if (flags_clr_i) m_ovr = 0;
            if (to_ev) m_tmo = 1;
            else if (flags_clr_i) m_tmo = 0;
            if (tick && !e_busy) begin
                m_act = 1;
                m_s = cyc + 1;
                if (adc_stuck || adc_lat >= TMO) begin
                    m_to = 1;
                    m_c = -10; m_d = -10;
                    m_end = m_s + TMO;
                end else begin
                    m_to = 0;
                    m_c = m_s + 1 + adc_lat;
                    m_d = m_c + 2 + FL;
                    m_end = m_d + 1 + dac_lat;
                end
            end
            m_per = enable_i ? (m_per + 1) % DIV : 0;
        end
    end

    task automatic wait_pulse(input bit dac, input int budget,
                              output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((!dac && adc_start_o) || (dac && dac_start_o)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_chk++;
            $display("FAIL wait_%s: no pulse within %0d cycles",
                     dac ? "dac_start" : "adc_start", budget);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        flags_clr_i = 1'b1;
        step(1);
        flags_clr_i = 1'b0;
    endtask

    int rel, t0, t1, td, ta, tb2, tc, tr, tz, nb;

    initial begin
        reset_ni = 1'b0; enable_i = 1'b0; mode_i = 2'd1;
        flags_clr_i = 1'b0; adc_data_i = 16'h1234;
        step(3);
        chk("init_cnt", sample_cnt_o, 16'h0000);
        chk("init_busy", busy_o, 1'b0);
        reset_ni = 1'b1; enable_i = 1'b1; rel = cyc;

        // Normal bypass samples
        wait_pulse(0, 60, t0);
        chk("first_start_lat", t0 - rel, 50);
        wait_pulse(1, 60, td);
        chk("start_to_dac", td - t0, 24);
        step(1);
        chk("bypass_data", dac_data_o, 16'h1234);
        chk("cnt_one", sample_cnt_o, 16'd1);
        wait_pulse(0, 60, t1);
        chk("period_spacing", t1 - t0, 50);
        wait_pulse(1, 60, td);

        // Filtered and mute modes
        mode_i = 2'd2;
        wait_pulse(1, 80, td); step(1);
        chk("filtered_data", dac_data_o, 16'hEDCC);
        mode_i = 2'd0;
        wait_pulse(1, 80, td); step(1);
        chk("mute0_data", dac_data_o, 16'h0000);
        mode_i = 2'd1;
        wait_pulse(1, 80, td); step(1);
        chk("bypass_again", dac_data_o, 16'h1234);
        mode_i = 2'd3;
        wait_pulse(1, 80, td); step(1);
        chk("mute3_data", dac_data_o, 16'h0000);
        chk("cnt_six", sample_cnt_o, 16'd6);
        chk("strobes_six", n_stb, 6);
        mode_i = 2'd1;

        // Overrun: ADC busy longer than one period
        adc_lat = 70;
        wait_pulse(0, 60, ta);
        step(50);
        chk("overrun_set", overrun_o, 1'b1);
        wait_pulse(0, 120, tb2);
        chk("overrun_dropped_tick", tb2 - ta, 100);
        pulse_clr();
        chk("overrun_cleared", overrun_o, 1'b0);
        wait_pulse(1, 150, td);

        // Timeout: ADC never returns to idle
        adc_lat = 20; adc_stuck = 1'b1;
        pulse_clr();
        wait_pulse(0, 60, tc);
        step(49);
        flags_clr_i = 1'b1;
        step(1);
        flags_clr_i = 1'b0;
        chk("set_beats_clear", overrun_o, 1'b1);
        step(150);
        chk("timeout_not_early", timeout_o, 1'b0);
        step(1);
        chk("timeout_set", timeout_o, 1'b1);
        chk("idle_after_timeout", busy_o, 1'b0);
        adc_stuck = 1'b0;
        wait_pulse(0, 60, tr);
        chk("restart_after_timeout", tr - tc, 250);
        wait_pulse(1, 60, td);
        pulse_clr();
        chk("clr_timeout", timeout_o, 1'b0);
        chk("clr_overrun", overrun_o, 1'b0);

        // Counter wrap, then enable dropped mid-sample
        step(10);
        force dut.r_sample_cnt = 16'hFFFF;
        preload_seq = preload_seq + 1;
        #1;
        release dut.r_sample_cnt;
        wait_pulse(0, 30, t0);
        step(5);
        enable_i = 1'b0;
        wait_pulse(1, 60, td);
        step(1);
        chk("cnt_wrap", sample_cnt_o, 16'h0000);
        nb = n_adcm;
        step(120);
        chk("no_start_disabled", n_adcm - nb, 0);

        // Reset in DAC_WAIT
        enable_i = 1'b1;
        wait_pulse(1, 90, td);
        @(posedge clk); #3;
        reset_ni = 1'b0;
        #1;
        chk("async_busy", busy_o, 1'b0);
        chk("async_cnt", sample_cnt_o, 16'h0000);
        chk("async_dac_data", dac_data_o, 16'h0000);
        chk("async_filt_data", filt_data_o, 16'h0000);
        chk("async_dac_start", dac_start_o, 1'b0);
        step(3);
        reset_ni = 1'b1; rel = cyc;
        wait_pulse(0, 70, tz);
        chk("start_after_reset", tz - rel, 50);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
